// File: rtl/string_op_sequencer_if.sv
// rtl/string_op_sequencer_if.sv - FIFO A/B pop/flush bundle between sequencer and word FIFOs
interface string_op_sequencer_if;
   logic        a_empty;
   logic [31:0] a_data;
   logic        a_pop;
   logic        b_empty;
   logic [31:0] b_data;
   logic        b_pop;
   logic        fifo_flush;

   // sequencer side: consumes head words, issues pops and flush
   modport master (
      input  a_empty, a_data, b_empty, b_data,
      output a_pop, b_pop, fifo_flush
   );

   // FIFO side: presents show-ahead heads, obeys pops and flush
   modport slave (
      output a_empty, a_data, b_empty, b_data,
      input  a_pop, b_pop, fifo_flush
   );
endinterface

// File: rtl/string_op_sequencer.sv
// rtl/string_op_sequencer.sv - byte-serial LEN/FIND/CMP engine fed from word FIFOs A and B
module string_op_sequencer #(
   parameter int MAX_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_go,
   input  logic [1:0]                   i_op,
   input  logic [7:0]                   i_key,
   string_op_sequencer_if.master        fifo,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_error,
   output logic [31:0]                  o_result
);

   localparam int          POS_W     = $clog2(4 * MAX_WORDS) + 1;
   localparam int          WCNT_W    = $clog2(MAX_WORDS) + 1;
   localparam logic [WCNT_W-1:0] MAX_WCNT = WCNT_W'(MAX_WORDS);
   localparam logic [31:0] LEN_LIMIT = 32'(4 * MAX_WORDS);
   localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

   localparam logic [1:0]  OP_LEN  = 2'd0;
   localparam logic [1:0]  OP_FIND = 2'd1;
   localparam logic [1:0]  OP_CMP  = 2'd2;
   localparam logic [1:0]  OP_RSVD = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SCAN, S_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_op, w_op_nxt;
   logic [7:0]          r_key, w_key_nxt;
   logic [31:0]         r_word_a, w_word_a_nxt;
   logic [31:0]         r_word_b, w_word_b_nxt;
   logic [1:0]          r_idx, w_idx_nxt;
   logic [POS_W-1:0]    r_pos, w_pos_nxt;
   logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
   logic                r_error, w_error_nxt;
   logic [31:0]         r_result, w_result_nxt;

   logic                w_a_pop, w_b_pop;
   logic                w_need_b;
   logic                w_term;
   logic [7:0]          w_byte_a, w_byte_b;
   logic [8:0]          w_diff;
   logic [31:0]         w_diff_ext;
   logic [31:0]         w_pos_ext;

   // select the current byte of each latched word, most significant byte first
   always_comb begin
      w_byte_a = r_word_a[31:24];
      w_byte_b = r_word_b[31:24];
      case (r_idx)
         2'd0: begin w_byte_a = r_word_a[31:24]; w_byte_b = r_word_b[31:24]; end
         2'd1: begin w_byte_a = r_word_a[23:16]; w_byte_b = r_word_b[23:16]; end
         2'd2: begin w_byte_a = r_word_a[15:8];  w_byte_b = r_word_b[15:8];  end
         default: begin w_byte_a = r_word_a[7:0]; w_byte_b = r_word_b[7:0]; end
      endcase
   end

   // compare difference is a 9-bit signed value so 0x01-0xFF stays negative
   assign w_diff     = {1'b0, w_byte_a} - {1'b0, w_byte_b};
   assign w_diff_ext = {{23{w_diff[8]}}, w_diff};
   assign w_pos_ext  = {{(32 - POS_W){1'b0}}, r_pos};
   assign w_need_b   = (r_op == OP_CMP);

   // next-state, pop strobes and datapath updates
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_key_nxt    = r_key;
      w_word_a_nxt = r_word_a;
      w_word_b_nxt = r_word_b;
      w_idx_nxt    = r_idx;
      w_pos_nxt    = r_pos;
      w_wcnt_nxt   = r_wcnt;
      w_error_nxt  = r_error;
      w_result_nxt = r_result;
      w_a_pop      = 1'b0;
      w_b_pop      = 1'b0;
      w_term       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_go) begin
               w_op_nxt     = i_op;
               w_key_nxt    = i_key;
               w_error_nxt  = 1'b0;
               w_result_nxt = 32'h0;
               w_pos_nxt    = '0;
               w_wcnt_nxt   = '0;
               if (i_op == OP_RSVD) begin
                  w_error_nxt  = 1'b1;
                  w_result_nxt = ALL_ONES;
                  w_state_nxt  = S_DONE;
               end else begin
                  w_state_nxt  = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            if (!fifo.a_empty && (!w_need_b || !fifo.b_empty)) begin
               w_a_pop      = 1'b1;
               w_b_pop      = w_need_b;
               w_word_a_nxt = fifo.a_data;
               if (w_need_b) w_word_b_nxt = fifo.b_data;
               w_idx_nxt    = 2'd0;
               w_wcnt_nxt   = r_wcnt + WCNT_W'(1);
               w_state_nxt  = S_SCAN;
            end else begin
               // underrun: no waiting for data
               w_error_nxt  = 1'b1;
               w_result_nxt = ALL_ONES;
               w_state_nxt  = S_DONE;
            end
         end
         S_SCAN: begin
            case (r_op)
               OP_LEN: begin
                  if (w_byte_a == 8'h00) begin
                     w_term       = 1'b1;
                     w_result_nxt = w_pos_ext;
                  end
               end
               OP_FIND: begin
                  // key match wins, so a NUL key reports the NUL position
                  if (w_byte_a == r_key) begin
                     w_term       = 1'b1;
                     w_result_nxt = w_pos_ext;
                  end else if (w_byte_a == 8'h00) begin
                     w_term       = 1'b1;
                     w_result_nxt = ALL_ONES;
                  end
               end
               OP_CMP: begin
                  if (w_byte_a != w_byte_b) begin
                     w_term       = 1'b1;
                     w_result_nxt = w_diff_ext;
                  end else if (w_byte_a == 8'h00) begin
                     w_term       = 1'b1;
                     w_result_nxt = 32'h0;
                  end
               end
               default: w_term = 1'b1;
            endcase
            if (w_term) begin
               w_state_nxt = S_DONE;
            end else begin
               w_pos_nxt = r_pos + POS_W'(1);
               if (r_idx != 2'd3) begin
                  w_idx_nxt = r_idx + 2'd1;
               end else if (r_wcnt < MAX_WCNT) begin
                  w_state_nxt = S_FETCH;
               end else begin
                  // word limit reached: string treated as terminated here
                  w_state_nxt = S_DONE;
                  case (r_op)
                     OP_LEN:  w_result_nxt = LEN_LIMIT;
                     OP_FIND: w_result_nxt = ALL_ONES;
                     default: w_result_nxt = 32'h0;
                  endcase
               end
            end
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op     <= OP_LEN;
         r_key    <= 8'h00;
         r_word_a <= 32'h0;
         r_word_b <= 32'h0;
         r_idx    <= 2'd0;
         r_pos    <= '0;
         r_wcnt   <= '0;
         r_error  <= 1'b0;
         r_result <= 32'h0;
      end else begin
         r_op     <= w_op_nxt;
         r_key    <= w_key_nxt;
         r_word_a <= w_word_a_nxt;
         r_word_b <= w_word_b_nxt;
         r_idx    <= w_idx_nxt;
         r_pos    <= w_pos_nxt;
         r_wcnt   <= w_wcnt_nxt;
         r_error  <= w_error_nxt;
         r_result <= w_result_nxt;
      end
   end

   assign fifo.a_pop      = w_a_pop;
   assign fifo.b_pop      = w_b_pop;
   assign fifo.fifo_flush = (r_state == S_DONE);
   assign o_done          = (r_state == S_DONE);
   assign o_busy          = (r_state != S_IDLE);
   assign o_error         = r_error;
   assign o_result        = r_result;

endmodule

// File: tb/tb_string_op_sequencer.sv
// tb/tb_string_op_sequencer.sv - directed scoreboard bench for string_op_sequencer
module tb_string_op_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_go;
   logic [1:0]  i_op;
   logic [7:0]  i_key;
   logic        o_busy, o_done, o_error;
   logic [31:0] o_result;

   always #5 clk = ~clk;

   string_op_sequencer_if fif ();

   string_op_sequencer #(.MAX_WORDS(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_go     (i_go),
      .i_op     (i_op),
      .i_key    (i_key),
      .fifo     (fif),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_error  (o_error),
      .o_result (o_result)
   );

   typedef struct {
      logic [31:0] result;
      logic        error;
      int          lat;
      int          apops;
      int          bpops;
   } exp_t;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          n_apop, n_bpop;
   logic        s_apop, s_bpop, s_flush, s_done, s_busy, s_error;
   logic [31:0] s_result;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      fif.a_empty = (qa.size() == 0);
      fif.a_data  = (qa.size() != 0) ? qa[0] : 32'h0;
      fif.b_empty = (qb.size() == 0);
      fif.b_data  = (qb.size() != 0) ? qb[0] : 32'h0;
   endtask

   task automatic cyc();
      @(negedge clk);
      s_apop   = fif.a_pop;
      s_bpop   = fif.b_pop;
      s_flush  = fif.fifo_flush;
      s_done   = o_done;
      s_busy   = o_busy;
      s_error  = o_error;
      s_result = o_result;
      if (s_apop) n_apop++;
      if (s_bpop) n_bpop++;
      @(posedge clk);
      #1;
      if (s_flush) begin
         qa.delete();
         qb.delete();
      end else begin
         if (s_apop && qa.size() != 0) void'(qa.pop_front());
         if (s_bpop && qb.size() != 0) void'(qb.pop_front());
      end
      refresh();
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] key,
                         input logic [31:0] er, input logic ee, input int elat,
                         input int eap, input int ebp, input int poke_at);
      exp_t e, g;
      bit   seen;
      e.result = er; e.error = ee; e.lat = elat; e.apops = eap; e.bpops = ebp;
      sb.push_back(e);
      seen   = 1'b0;
      n_apop = 0;
      n_bpop = 0;
      refresh();
      i_op  = op;
      i_key = key;
      i_go  = 1'b1;
      cyc();
      i_go  = 1'b0;
      check({name, "_busy_at_go"}, 32'(s_busy), 32'd0);
      for (int k = 1; k <= 60 && !seen; k++) begin
         if (k == poke_at) begin
            i_go = 1'b1;
            i_op = 2'd3;
         end
         cyc();
         i_go = 1'b0;
         if (k <= elat) check({name, "_busy"}, 32'(s_busy), 32'd1);
         check({name, "_flush"}, 32'(s_flush), 32'(k == elat));
         if (s_done) begin
            seen = 1'b1;
            g = sb.pop_front();
            check({name, "_result"}, s_result, g.result);
            check({name, "_error"}, 32'(s_error), 32'(g.error));
            check({name, "_latency"}, 32'(k), 32'(g.lat));
            check({name, "_a_pops"}, 32'(n_apop), 32'(g.apops));
            check({name, "_b_pops"}, 32'(n_bpop), 32'(g.bpops));
         end
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      cyc();
      check({name, "_idle_busy"}, 32'(s_busy), 32'd0);
      check({name, "_idle_done"}, 32'(s_done), 32'd0);
      check({name, "_held_result"}, s_result, er);
      check({name, "_a_flushed"}, 32'(qa.size()), 32'd0);
      check({name, "_b_flushed"}, 32'(qb.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      i_go  = 1'b0;
      i_op  = 2'd0;
      i_key = 8'h00;
      refresh();
      cyc();
      check("rst_busy", 32'(s_busy), 32'd0);
      check("rst_done", 32'(s_done), 32'd0);
      check("rst_a_pop", 32'(s_apop), 32'd0);
      check("rst_b_pop", 32'(s_bpop), 32'd0);
      check("rst_flush", 32'(s_flush), 32'd0);
      check("rst_error", 32'(s_error), 32'd0);
      check("rst_result", s_result, 32'h0);
      reset = 1'b0;
      cyc();

      qa.push_back(32'h68692100); qa.push_back(32'h11111111);
      run_op("len_hi", 2'd0, 8'h00, 32'd3, 1'b0, 6, 1, 0, 0);

      qa.push_back(32'h61626300); qb.push_back(32'h61626400);
      run_op("cmp_abc", 2'd2, 8'h00, 32'hFFFFFFFF, 1'b0, 5, 1, 1, 0);

      qa.push_back(32'h68656C6C); qa.push_back(32'h6F000000);
      run_op("find_o", 2'd1, 8'h6F, 32'd4, 1'b0, 8, 2, 0, 0);

      qa.push_back(32'h41424344);
      run_op("len_underrun", 2'd0, 8'h00, 32'hFFFFFFFF, 1'b1, 7, 1, 0, 0);

      for (int i = 0; i < 4; i++) begin
         qa.push_back(32'h41414141);
         qb.push_back(32'h41414141);
      end
      run_op("cmp_limit", 2'd2, 8'h00, 32'h0, 1'b0, 21, 4, 4, 0);

      qa.push_back(32'h41424300);
      run_op("reserved", 2'd3, 8'h00, 32'hFFFFFFFF, 1'b1, 1, 0, 0, 0);

      qa.push_back(32'h41004200);
      run_op("find_nul_key", 2'd1, 8'h00, 32'd1, 1'b0, 4, 1, 0, 0);

      qa.push_back(32'h41420000);
      run_op("find_absent", 2'd1, 8'h5A, 32'hFFFFFFFF, 1'b0, 5, 1, 0, 0);

      for (int i = 0; i < 4; i++) qa.push_back(32'h41414141);
      run_op("len_limit", 2'd0, 8'h00, 32'd16, 1'b0, 21, 4, 0, 0);

      for (int i = 0; i < 4; i++) qa.push_back(32'h41414141);
      run_op("find_limit", 2'd1, 8'h7A, 32'hFFFFFFFF, 1'b0, 21, 4, 0, 0);

      qa.push_back(32'h80000000); qb.push_back(32'h01000000);
      run_op("cmp_pos", 2'd2, 8'h00, 32'h0000007F, 1'b0, 3, 1, 1, 0);

      qa.push_back(32'h01000000); qb.push_back(32'hFF000000);
      run_op("cmp_neg", 2'd2, 8'h00, 32'hFFFFFF02, 1'b0, 3, 1, 1, 0);

      qa.push_back(32'h68692100);
      run_op("go_while_busy", 2'd0, 8'h00, 32'd3, 1'b0, 6, 1, 0, 3);

      qa.push_back(32'h68692100);
      run_op("go_in_done", 2'd0, 8'h00, 32'd3, 1'b0, 6, 1, 0, 6);

      // abort during SCAN
      qa.push_back(32'h41424344); qa.push_back(32'h45464700);
      refresh();
      i_op = 2'd0;
      i_go = 1'b1;
      cyc();
      i_go = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check("abort_busy", 32'(s_busy), 32'd0);
         check("abort_done", 32'(s_done), 32'd0);
         check("abort_flush", 32'(s_flush), 32'd0);
         check("abort_a_pop", 32'(s_apop), 32'd0);
         check("abort_error", 32'(s_error), 32'd0);
         check("abort_result", s_result, 32'h0);
      end
      check("abort_fifo_kept", 32'(qa.size()), 32'd1);
      reset = 1'b0;
      qa.delete();
      cyc();

      qa.push_back(32'h68692100);
      run_op("len_after_reset", 2'd0, 8'h00, 32'd3, 1'b0, 6, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/string_op_sequencer.md
# string_op_sequencer

Controller that sequences the string hardware accelerator's word FIFOs through a byte-serial string engine. On a `go` pulse it pops 32-bit words from FIFO A (and FIFO B for compares) and unpacks each word into four bytes. It runs one of three operations (length, find-byte, compare) and reports a 32-bit result with a one-cycle `done` pulse. It sits between the Avalon register front end, which drives `go`, `op` and `key` and reads back the result, and the FIFO A/B storage.

## Interface
- `MAX_WORDS`, default 4: maximum words consumed per string; a string reaching this limit without a NUL is treated as terminated there.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `go`  in  1  start strobe; sampled only in IDLE.
- `op`  in  2  operation code: 0 = LEN, 1 = FIND, 2 = CMP, 3 = reserved.
- `key`  in  8  byte searched for by FIND.
- `a_empty`  in  1  FIFO A empty.
- `a_data`  in  32  FIFO A head word (show-ahead: valid whenever `a_empty` = 0).
- `a_pop`  out  1  consume the FIFO A head this cycle.
- `b_empty`, `b_data`, `b_pop`  in/in/out  1/32/1  FIFO B equivalents.
- `fifo_flush`  out  1  one-cycle pulse that clears both FIFOs.
- `busy`  out  1  high from the cycle after an accepted `go` until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  error status of the last operation; held until the next accepted `go`.
- `result`  out  32  result of the last operation; held until the next accepted `go`.

## Operation
- States: IDLE, FETCH, SCAN, DONE.
- IDLE:
  - `go` = 1 latches `op`/`key`, clears `error`/`result`/position/word counters, then goes to FETCH.
  - If `op` = 3, the block goes directly to DONE with `error` = 1, `result` = 0xFFFFFFFF and no pops.
- FETCH:
  - LEN/FIND need A non-empty; CMP needs both A and B non-empty.
  - If the needed FIFOs are non-empty: assert the pop(s) for one cycle, latch the word(s), set byte index 0, increment the word count, go to SCAN.
  - Otherwise (underrun): `error` = 1, `result` = 0xFFFFFFFF, go to DONE. No waiting.
- SCAN: one byte per cycle. Byte order is big-endian: index 0 = bits [31:24], index 3 = bits [7:0].
  - LEN: byte == 0x00 → `result` = position, go to DONE; else position++.
  - FIND: byte == `key` → `result` = position, go to DONE. Otherwise, byte == 0x00 → `result` = 0xFFFFFFFF (not found, `error` = 0), go to DONE. Otherwise position++. The key test takes precedence, so `key` = 0x00 returns the NUL position.
  - CMP:
    - a ≠ b → `result` = signed 9-bit (a − b) sign-extended to 32 bits, go to DONE.
    - a == b == 0x00 → `result` = 0, go to DONE.
    - Otherwise position++.
  - After index 3 with no terminating event:
    - If word count < `MAX_WORDS`, go to FETCH.
    - Otherwise terminate by limit, go to DONE, `error` = 0, with:
      - LEN: `result` = 4·`MAX_WORDS`.
      - FIND: `result` = 0xFFFFFFFF.
      - CMP: `result` = 0.
- DONE:
  - `done` = 1 and `fifo_flush` = 1 for one cycle, then IDLE.
  - Unscanned bytes and any remaining FIFO words are discarded by the flush.
- Position counter is clog2(4·`MAX_WORDS`)+1 bits wide and is zero-extended into `result`.
- `go` while not in IDLE is ignored.
- `go` in the DONE cycle is ignored. `go` in the first IDLE cycle after DONE is accepted.

## Timing
- Reset values: `busy`, `done`, `a_pop`, `b_pop`, `fifo_flush`, `error` = 0; `result` = 0; state IDLE.
- Reset mid-operation aborts at once: no `done`, no flush; the FIFOs keep their contents.
- Latency, with `go` sampled at cycle T:
  - FETCH runs at T+1.
  - Byte index i of word w (counted from 0) is scanned at T+2 + 5w + i.
  - DONE (`done` pulse) follows one cycle after the terminating byte.
- Underrun: DONE occurs in the cycle after the failing FETCH.
- Reserved op: `done` at T+1.
- `a_pop`/`b_pop` are asserted only in FETCH, at most once per word.
- `result` and `error` are stable by the DONE cycle and held through IDLE.

## Test plan
- LEN, A = {0x68692100}, `go` at T → one `a_pop` at T+1, `done` at T+6, `result` = 3, `error` = 0, `fifo_flush` with `done`.
- CMP, A = {0x61626300}, B = {0x61626400} → `a_pop` and `b_pop` once each, `result` = 0xFFFFFFFF (0x63 − 0x64), `done` at T+5.
- FIND `key` = 0x6F, A = {0x68656C6C, 0x6F000000} → two `a_pop`s (T+1, T+6), `result` = 4, `done` at T+8.
- LEN underrun, A = {0x41424344} and then empty → `error` = 1, `result` = 0xFFFFFFFF, `done` at T+7.
- CMP with `MAX_WORDS` = 4, A = B = four words 0x41414141 → four pops each, `result` = 0, `error` = 0; then `op` = 3 → `error` = 1, `done` at T+1, no pops.
- Robustness:
  - `go` while busy has no effect.
  - Asserting `reset` during SCAN clears all outputs, with no `done`.
  - A fresh LEN after reset behaves as in the first scenario.
